bpu_btb: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage RISC-V pipeline. It is looked up combinationally by the IF stage with the current PC and returns a predicted next PC. It is trained by the ID stage, where branches and jumps resolve, which lets the pipeline fetch predicted-taken targets instead of always fetching PC+4 and flushing on taken branches. It also flags mispredictions for the ID-stage flush logic and keeps wrap-around performance counters.

---
 rtl/bpu_btb.sv | 114 +++++++++++
 tb/tb_bpu_btb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped branch target buffer with 2-bit saturating
// direction counters. The IF stage looks it up combinationally with the
// current PC. The ID stage trains it with resolved branches and jumps.
// It also flags mispredictions and keeps wrap-around performance counters.
module bpu_btb #(
    parameter int         ENTRIES  = 16,
    parameter int         TAG_W    = 30 - $clog2(ENTRIES),
    parameter logic [1:0] CTR_INIT = 2'b10,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      lk_pc,
    output logic             lk_hit,
    output logic             lk_taken,
    output logic [31:0]      lk_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] perf_updates,
    output logic [CNT_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CNT_W-1:0] r_perfUpdates;
    logic [CNT_W-1:0] r_perfMispredicts;

    logic [IDX_W-1:0] w_lkIdx;
    logic [TAG_W-1:0] w_lkTag;
    logic [IDX_W-1:0] w_updIdx;
    logic [TAG_W-1:0] w_updTag;
    logic             w_updHit;
    logic             w_tableWrite;
    logic             w_targetWrite;
    logic [1:0]       w_curCtr;
    logic [1:0]       w_nextCtr;

    assign w_lkIdx  = lk_pc[IDX_W+1:2];
    assign w_lkTag  = lk_pc[31:IDX_W+2];
    assign w_updIdx = upd_pc[IDX_W+1:2];
    assign w_updTag = upd_pc[31:IDX_W+2];

    assign lk_hit    = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
    assign lk_taken  = lk_hit && r_ctr[w_lkIdx][1];
    assign lk_target = lk_taken ? r_target[w_lkIdx] : (lk_pc + 32'd4);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    assign w_updHit      = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_curCtr      = r_ctr[w_updIdx];
    // A miss only allocates when taken; a not-taken miss leaves the table alone.
    assign w_tableWrite  = upd_valid && (w_updHit || upd_taken);
    assign w_targetWrite = upd_is_jump || upd_taken;

    assign perf_updates     = r_perfUpdates;
    assign perf_mispredicts = r_perfMispredicts;

    // Next counter value for the entry being trained: jumps pin it to strongly taken,
    // branches walk it with saturation, and a fresh branch allocation starts at CTR_INIT.
    always_comb begin
        w_nextCtr = w_curCtr;
        if (!w_updHit) begin
            w_nextCtr = upd_is_jump ? 2'b11 : CTR_INIT;
        end else if (upd_is_jump) begin
            w_nextCtr = 2'b11;
        end else if (upd_taken) begin
            w_nextCtr = (w_curCtr == 2'b11) ? 2'b11 : w_curCtr + 2'b01;
        end else begin
            w_nextCtr = (w_curCtr == 2'b00) ? 2'b00 : w_curCtr - 2'b01;
        end
    end

    // Table and counter state: reset clears everything and swallows any coincident update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= 2'b00;
                r_target[i] <= 32'd0;
            end
            r_perfUpdates     <= '0;
            r_perfMispredicts <= '0;
        end else begin
            if (w_tableWrite) begin
                r_valid[w_updIdx] <= 1'b1;
                r_tag[w_updIdx]   <= w_updTag;
                r_ctr[w_updIdx]   <= w_nextCtr;
                if (w_targetWrite) begin
                    r_target[w_updIdx] <= upd_target;
                end
            end
            if (upd_valid) begin
                r_perfUpdates <= r_perfUpdates + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mispredict) begin
                r_perfMispredicts <= r_perfMispredicts + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_bpu_btb.sv
// tb_bpu_btb: scoreboard bench for bpu_btb. The driver computes expected
// responses from a table model and queues them. A monitor pops and compares
// them against the sampled outputs. A second instance with 4-bit perf
// counters exercises counter wrap-around.
module tb_bpu_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lk_pc;
    logic        lk_hit, lk_taken;
    logic [31:0] lk_target;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] perf_updates, perf_mispredicts;

    logic        lk_hit4, lk_taken4, mispredict4;
    logic [31:0] lk_target4;
    logic [3:0]  perf_updates4, perf_mispredicts4;

    always #5 clk = ~clk;

    bpu_btb dut (
        .clk(clk), .reset(reset), .lk_pc(lk_pc),
        .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict),
        .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
    );

    bpu_btb #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .lk_pc(lk_pc),
        .lk_hit(lk_hit4), .lk_taken(lk_taken4), .lk_target(lk_target4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict4),
        .perf_updates(perf_updates4), .perf_mispredicts(perf_mispredicts4)
    );

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] pu;
        logic [31:0] pm;
        logic [3:0]  pu4;
        logic [3:0]  pm4;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stimDone = 0;

    // Reference model: per-slot valid, full upper PC bits, integer counter, target.
    bit          mValid [16];
    logic [31:0] mTagPc [16];
    int          mCtr   [16];
    logic [31:0] mTgt   [16];
    logic [31:0] mPu, mPm;

    function automatic int slotOf(logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit modelHit(logic [31:0] pc);
        return mValid[slotOf(pc)] && (mTagPc[slotOf(pc)] == (pc >> 6));
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 0; mTagPc[i] = 0; mCtr[i] = 0; mTgt[i] = 0;
        end
        mPu = 0;
        mPm = 0;
    endtask

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, queue the expected response,
    // then advance the model as the coming rising edge will.
    task automatic applyStimulus(input logic [31:0] lkPc, input bit uv, input logic [31:0] pc,
                                 input bit isJump, input bit tk, input logic [31:0] tgt,
                                 input bit pTk, input logic [31:0] pTgt, input bit rstN);
        exp_t e;
        int   s;
        bit   mis;
        @(negedge clk);
        reset = rstN; lk_pc = lkPc; upd_valid = uv; upd_pc = pc; upd_is_jump = isJump;
        upd_taken = tk; upd_target = tgt; upd_pred_taken = pTk; upd_pred_target = pTgt;

        s        = slotOf(lkPc);
        e.hit    = modelHit(lkPc);
        e.taken  = e.hit && (mCtr[s] >= 2);
        e.target = e.taken ? mTgt[s] : lkPc + 32'd4;
        mis      = uv && ((tk != pTk) || (tk && (tgt != pTgt)));
        e.mis    = mis;
        e.pu     = mPu;
        e.pm     = mPm;
        e.pu4    = mPu[3:0];
        e.pm4    = mPm[3:0];
        expQ.push_back(e);

        if (!rstN) begin
            modelClear();
        end else if (uv) begin
            s = slotOf(pc);
            mPu++;
            if (mis) mPm++;
            if (modelHit(pc)) begin
                if (isJump) begin
                    mCtr[s] = 3; mTgt[s] = tgt;
                end else if (tk) begin
                    mCtr[s] = (mCtr[s] + 1 > 3) ? 3 : mCtr[s] + 1; mTgt[s] = tgt;
                end else begin
                    mCtr[s] = (mCtr[s] - 1 < 0) ? 0 : mCtr[s] - 1;
                end
            end else if (tk) begin
                mValid[s] = 1; mTagPc[s] = pc >> 6; mTgt[s] = tgt;
                mCtr[s] = isJump ? 3 : 2;
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("lk_hit", {31'd0, lk_hit}, {31'd0, e.hit});
        cmp("lk_taken", {31'd0, lk_taken}, {31'd0, e.taken});
        cmp("lk_target", lk_target, e.target);
        cmp("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
        cmp("perf_updates", perf_updates, e.pu);
        cmp("perf_mispredicts", perf_mispredicts, e.pm);
        cmp("perf_updates_w4", {28'd0, perf_updates4}, {28'd0, e.pu4});
        cmp("perf_mispredicts_w4", {28'd0, perf_mispredicts4}, {28'd0, e.pm4});
    endtask

    // Monitor: sample well after the falling edge, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    function automatic logic [31:0] pickPc();
        case ($urandom_range(0, 4))
            0: return 32'h100;
            1: return 32'h140;
            2: return 32'h80;
            3: return 32'h1C4 | $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    // Directed sequence from the test plan, then randomized traffic.
    initial begin
        logic [31:0] p, t;
        bit          j, tk, ptk;
        reset = 1'b0; lk_pc = 32'h100; upd_valid = 0; upd_pc = 0; upd_is_jump = 0;
        upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
        repeat (2) @(posedge clk);
        modelClear();

        applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0, 1);
        applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) applyStimulus(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 1);
        applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(32'h100, 1, 32'h100, 0, 1, 32'h40, 1, 32'h40, 1);
        applyStimulus(32'h100, 1, 32'h140, 0, 1, 32'h200, 0, 0, 1);
        applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(32'h140, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(32'h80, 1, 32'h80, 1, 1, 32'h20, 0, 0, 1);
        applyStimulus(32'h80, 1, 32'h80, 1, 1, 32'h24, 1, 32'h20, 1);
        applyStimulus(32'h80, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(32'h300, 1, 32'h300, 0, 1, 32'h500, 0, 0, 0);
        applyStimulus(32'h300, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (17) applyStimulus(32'h104, 1, 32'h104, 0, 1, 32'h60, 0, 0, 1);

        for (int n = 0; n < 400; n++) begin
            p   = pickPc();
            j   = ($urandom_range(0, 3) == 0);
            tk  = j ? 1'b1 : 1'($urandom_range(0, 1));
            t   = ($urandom_range(0, 1) == 1) ? 32'h40 : ($urandom & 32'hFFFF_FFFC);
            ptk = 1'($urandom_range(0, 1));
            applyStimulus(pickPc(), ($urandom_range(0, 3) != 0), p, j, tk, t, ptk,
                          (($urandom_range(0, 1) == 1) ? t : 32'h40),
                          ($urandom_range(0, 49) != 0));
        end

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        #4;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
